// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle RV32I sequencer and its datapath.
// The slave modport is the sequencer side (decode fields in, enables and
// selects out); the master modport is the datapath/memory side.
// state_dbg carries the sequencer's current state for observation.
interface multicycle_control_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic [1:0] imm_src;
  logic       reg_write;
  logic       illegal;
  logic [3:0] state_dbg;

  modport slave (
    input  op, funct3, funct7b5, zero, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, result_src,
           alu_src_a, alu_src_b, alu_control, imm_src, reg_write,
           illegal, state_dbg
  );

  modport master (
    output op, funct3, funct7b5, zero, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, result_src,
           alu_src_a, alu_src_b, alu_control, imm_src, reg_write,
           illegal, state_dbg
  );
endinterface

// File: rtl/multicycle_control.sv
// Main sequencer for the multicycle RV32I core: a Moore FSM that steps each
// instruction through fetch/decode/execute/writeback and drives every
// datapath enable and mux select.
// Optional feature: define MULTICYCLE_JALR_EN to support jalr (opcode
// 1100111) via the JALR_ADR state; otherwise that opcode is illegal.
//
// Memory handshake: the sequencer holds a memory request (FETCH, MEMREAD,
// MEMWRITE) with all selects stable for as long as mem_ready is low; the
// access completes in the first cycle mem_ready is high, and only then do
// the completion enables (ir_write/pc_write in FETCH) fire and the state
// advance. mem_write stays high for the whole request.
module multicycle_control (
  input  logic                        clk,
  input  logic                        rst,
  multicycle_control_if.slave         bus
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
`ifdef MULTICYCLE_JALR_EN
  localparam logic [6:0] OP_JALR = 7'b1100111;
`endif

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWRITE = 4'd4,
    MEMWB    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10
`ifdef MULTICYCLE_JALR_EN
    ,JALR_ADR = 4'd11
`endif
  } state_t;

  state_t     state, state_next;

  logic       pc_write_c;
  logic       adr_src_c;
  logic       mem_write_c;
  logic       ir_write_c;
  logic [1:0] result_src_c;
  logic [1:0] alu_src_a_c;
  logic [1:0] alu_src_b_c;
  logic [1:0] alu_op_c;
  logic [2:0] alu_control_c;
  logic [1:0] imm_src_c;
  logic       reg_write_c;
  logic       illegal_c;

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  // Next-state and Moore outputs (mem_ready/zero gate only where noted).
  always_comb begin
    state_next   = state;
    pc_write_c   = 1'b0;
    adr_src_c    = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    result_src_c = 2'b00;
    alu_src_a_c  = 2'b00;
    alu_src_b_c  = 2'b00;
    alu_op_c     = ALUOP_ADD;
    reg_write_c  = 1'b0;
    illegal_c    = 1'b0;
    case (state)
      FETCH: begin
        alu_src_b_c  = 2'b10;
        result_src_c = 2'b10;
        if (bus.mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        // Precompute PC-relative target into ALUOut for branch/jal.
        alu_src_a_c = 2'b01;
        alu_src_b_c = 2'b01;
        case (bus.op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECUTER;
          OP_I:         state_next = EXECUTEI;
          OP_BR:        state_next = BRANCH;
          OP_JAL:       state_next = JAL;
`ifdef MULTICYCLE_JALR_EN
          OP_JALR:      state_next = JALR_ADR;
`endif
          default: begin
            state_next = FETCH;
            illegal_c  = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a_c = 2'b10;
        alu_src_b_c = 2'b01;
        state_next  = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adr_src_c = 1'b1;
        if (bus.mem_ready) state_next = MEMWB;
      end
      MEMWRITE: begin
        adr_src_c   = 1'b1;
        mem_write_c = 1'b1;
        if (bus.mem_ready) state_next = FETCH;
      end
      MEMWB: begin
        result_src_c = 2'b01;
        reg_write_c  = 1'b1;
        state_next   = FETCH;
      end
      EXECUTER: begin
        alu_src_a_c = 2'b10;
        alu_op_c    = ALUOP_FUNCT;
        state_next  = ALUWB;
      end
      EXECUTEI: begin
        alu_src_a_c = 2'b10;
        alu_src_b_c = 2'b01;
        alu_op_c    = ALUOP_FUNCT;
        state_next  = ALUWB;
      end
      ALUWB: begin
        reg_write_c = 1'b1;
        state_next  = FETCH;
      end
      BRANCH: begin
        // beq takes the branch on zero, bne on not-zero.
        alu_src_a_c = 2'b10;
        alu_op_c    = ALUOP_SUB;
        pc_write_c  = bus.zero ^ bus.funct3[0];
        state_next  = FETCH;
      end
      JAL: begin
        // PC <- ALUOut (target); ALU forms OldPC+4 for the link write.
        alu_src_a_c = 2'b01;
        alu_src_b_c = 2'b10;
        pc_write_c  = 1'b1;
        state_next  = ALUWB;
      end
`ifdef MULTICYCLE_JALR_EN
      JALR_ADR: begin
        // rs1+imm lands in ALUOut, then JAL loads it into PC.
        alu_src_a_c = 2'b10;
        alu_src_b_c = 2'b01;
        state_next  = JAL;
      end
`endif
      default: state_next = FETCH;
    endcase
  end

  // ALU operation: fixed add/sub or decoded from funct fields.
  always_comb begin
    alu_control_c = ALU_ADD;
    case (alu_op_c)
      ALUOP_SUB: alu_control_c = ALU_SUB;
      ALUOP_FUNCT: begin
        case (bus.funct3)
          3'b000:  alu_control_c = (bus.op[5] & bus.funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_c = ALU_SLT;
          3'b110:  alu_control_c = ALU_OR;
          3'b111:  alu_control_c = ALU_AND;
          default: alu_control_c = ALU_ADD;
        endcase
      end
      default: alu_control_c = ALU_ADD;
    endcase
  end

  // Immediate format follows the opcode directly.
  always_comb begin
    imm_src_c = 2'b00;
    case (bus.op)
      OP_SW:   imm_src_c = 2'b01;
      OP_BR:   imm_src_c = 2'b10;
      OP_JAL:  imm_src_c = 2'b11;
      default: imm_src_c = 2'b00;
    endcase
  end

  // Architectural enables are suppressed while reset is held.
  assign bus.pc_write    = pc_write_c  & ~rst;
  assign bus.ir_write    = ir_write_c  & ~rst;
  assign bus.mem_write   = mem_write_c & ~rst;
  assign bus.reg_write   = reg_write_c & ~rst;
  assign bus.illegal     = illegal_c   & ~rst;
  assign bus.adr_src     = adr_src_c;
  assign bus.result_src  = result_src_c;
  assign bus.alu_src_a   = alu_src_a_c;
  assign bus.alu_src_b   = alu_src_b_c;
  assign bus.alu_control = alu_control_c;
  assign bus.imm_src     = imm_src_c;
  assign bus.state_dbg   = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. Each step drives the decode fields
// for the current cycle, then compares the full control word against a
// hand-built expectation packed as
// {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
//  alu_src_b, alu_control, imm_src, reg_write, illegal}.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [16:0] obs;
  assign obs = {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write,
                bus.result_src, bus.alu_src_a, bus.alu_src_b,
                bus.alu_control, bus.imm_src, bus.reg_write, bus.illegal};

  function automatic logic [16:0] ctl(input logic pcw, input logic adr,
                                      input logic mw, input logic irw,
                                      input logic [1:0] rs, input logic [1:0] sa,
                                      input logic [1:0] sb, input logic [2:0] ac,
                                      input logic [1:0] imm, input logic rw,
                                      input logic ill);
    return {pcw, adr, mw, irw, rs, sa, sb, ac, imm, rw, ill};
  endfunction

  function automatic logic [16:0] e_fetch(input logic [1:0] imm);
    return ctl(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0, 0);
  endfunction

  function automatic logic [16:0] e_decode(input logic [1:0] imm);
    return ctl(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 0, 0);
  endfunction

  function automatic logic [16:0] e_aluwb(input logic [1:0] imm);
    return ctl(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1, 0);
  endfunction

  task automatic drive(input logic [6:0] op, input logic [2:0] f3,
                       input logic f7, input logic z, input logic mr);
    bus.op        = op;
    bus.funct3    = f3;
    bus.funct7b5  = f7;
    bus.zero      = z;
    bus.mem_ready = mr;
  endtask

  // Compare this cycle's outputs, then advance to just after the next edge.
  task automatic step(input string tag, input logic [16:0] exp);
    #1;
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    // Reset held: FETCH selects but every enable forced low.
    step("rst_c1", ctl(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0));
    step("rst_c2", ctl(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0));
    rst = 1'b0;

    // lw, mem_ready=1: 5 cycles, writeback from read data.
    step("lw_fetch",  e_fetch(2'b00));
    step("lw_decode", e_decode(2'b00));
    step("lw_memadr", ctl(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0));
    step("lw_memrd",  ctl(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0));
    step("lw_memwb",  ctl(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0));

    // sw with 3 stall cycles in MEMWRITE: 7 cycles total.
    drive(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1);
    step("sw_fetch",  e_fetch(2'b01));
    step("sw_decode", e_decode(2'b01));
    step("sw_memadr", ctl(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 0, 0));
    bus.mem_ready = 1'b0;
    step("sw_stall1", ctl(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0));
    step("sw_stall2", ctl(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0));
    step("sw_stall3", ctl(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0));
    bus.mem_ready = 1'b1;
    step("sw_memwr",  ctl(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0));

    // beq, with one fetch stall first (no enables while stalled).
    drive(7'b1100011, 3'b000, 1'b0, 1'b1, 1'b0);
    step("beq_fstall", ctl(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b10, 0, 0));
    bus.mem_ready = 1'b1;
    step("beq_fetch",  e_fetch(2'b10));
    step("beq_decode", e_decode(2'b10));
    step("beq_branch", ctl(1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 0, 0));

    // bne with zero=1: not taken.
    drive(7'b1100011, 3'b001, 1'b0, 1'b1, 1'b1);
    step("bne_fetch",  e_fetch(2'b10));
    step("bne_decode", e_decode(2'b10));
    step("bne_branch", ctl(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 0, 0));

    // R-type sub (funct3 000, funct7b5 1).
    drive(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b1);
    step("rsub_fetch",  e_fetch(2'b00));
    step("rsub_decode", e_decode(2'b00));
    step("rsub_exec",   ctl(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00, 0, 0));
    step("rsub_aluwb",  e_aluwb(2'b00));

    // I-type with the same fields: addi, funct7b5 ignored.
    drive(7'b0010011, 3'b000, 1'b1, 1'b0, 1'b1);
    step("iadd_fetch",  e_fetch(2'b00));
    step("iadd_decode", e_decode(2'b00));
    step("iadd_exec",   ctl(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0));
    step("iadd_aluwb",  e_aluwb(2'b00));

    // R-type slt, then and; I-type or.
    drive(7'b0110011, 3'b010, 1'b0, 1'b0, 1'b1);
    step("rslt_fetch",  e_fetch(2'b00));
    step("rslt_decode", e_decode(2'b00));
    step("rslt_exec",   ctl(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b101, 2'b00, 0, 0));
    step("rslt_aluwb",  e_aluwb(2'b00));
    drive(7'b0110011, 3'b111, 1'b0, 1'b0, 1'b1);
    step("rand_fetch",  e_fetch(2'b00));
    step("rand_decode", e_decode(2'b00));
    step("rand_exec",   ctl(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b010, 2'b00, 0, 0));
    step("rand_aluwb",  e_aluwb(2'b00));
    drive(7'b0010011, 3'b110, 1'b0, 1'b0, 1'b1);
    step("ior_fetch",   e_fetch(2'b00));
    step("ior_decode",  e_decode(2'b00));
    step("ior_exec",    ctl(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b011, 2'b00, 0, 0));
    step("ior_aluwb",   e_aluwb(2'b00));

    // jal: PC <- target, then link writeback.
    drive(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b1);
    step("jal_fetch",  e_fetch(2'b11));
    step("jal_decode", e_decode(2'b11));
    step("jal_jal",    ctl(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11, 0, 0));
    step("jal_aluwb",  e_aluwb(2'b11));

    // jalr opcode.
    drive(7'b1100111, 3'b000, 1'b0, 1'b0, 1'b1);
    step("jalr_fetch",  e_fetch(2'b00));
`ifdef MULTICYCLE_JALR_EN
    step("jalr_decode", e_decode(2'b00));
    step("jalr_adr",    ctl(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0));
    step("jalr_jal",    ctl(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b00, 0, 0));
    step("jalr_aluwb",  e_aluwb(2'b00));
`else
    step("jalr_illegal", ctl(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0, 1));
`endif

    // Unsupported opcode: single illegal pulse, back to FETCH.
    drive(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b1);
    step("ill_fetch",  e_fetch(2'b00));
    step("ill_decode", ctl(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0, 1));

    // Reset arriving in MEMWB suppresses the register write.
    drive(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b1);
    step("rlw_fetch",  e_fetch(2'b00));
    step("rlw_decode", e_decode(2'b00));
    step("rlw_memadr", ctl(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0));
    step("rlw_memrd",  ctl(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0));
    rst = 1'b1;
    step("rlw_memwb_rst", ctl(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0));
    rst = 1'b0;
    step("rlw_refetch", e_fetch(2'b00));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main sequencer for the multicycle RV32I core. Decodes the opcode latched in the instruction register and steps a Moore FSM that drives every datapath enable and mux select: PC/IR write, memory address source, ALU operand selects, ALU operation, result source and the sign-extender's immediate-format select. Memory accesses stall on a ready handshake.

## Interface
- No parameters.
- clk  in  1  core clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- op  in  7  instr[6:0] from IR
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  PC load enable
- adr_src  out  1  memory address: 0 PC, 1 result bus
- mem_write  out  1  data memory write strobe
- ir_write  out  1  IR and OldPC load enable
- result_src  out  2  00 ALUOut, 01 read data, 10 ALU result
- alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1
- alu_src_b  out  2  00 rs2, 01 immext, 10 constant 4
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- imm_src  out  2  immediate format for sign extender: 00 I, 01 S, 10 B, 11 J
- reg_write  out  1  register-file write enable
- illegal  out  1  one-cycle pulse on unsupported opcode

## Operation
- Opcodes: 0000011 lw, 0100011 sw, 0110011 R, 0010011 I-ALU, 1100011 branch, 1101111 jal; 1100111 jalr under macro.
- imm_src combinational from op: lw/I-ALU/jalr 00, sw 01, branch 10, jal 11, others 00.
- Internal alu_op per state: 00 add, 01 sub, 10 funct-decode. Funct decode: funct3 000 → sub if op[5]&funct7b5 else add; 010 slt; 110 or; 111 and; any other funct3 → add.
- States and outputs (unlisted outputs 0):
- FETCH: adr_src 0, alu_src_a 00, alu_src_b 10, add, result_src 10; if mem_ready: ir_write=1, pc_write=1, → DECODE; else hold.
- DECODE: alu_src_a 01, alu_src_b 01, add (branch/jal target into ALUOut). → MEMADR (lw/sw), EXECUTER, EXECUTEI, BRANCH, JAL, JALR_ADR; illegal opcode → FETCH with illegal=1.
- MEMADR: alu_src_a 10, alu_src_b 01, add; → MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: adr_src 1, result_src 00; hold until mem_ready, then → MEMWB.
- MEMWRITE: adr_src 1, result_src 00, mem_write=1; hold until mem_ready, then → FETCH. mem_write stays high throughout the hold.
- MEMWB: result_src 01, reg_write=1; → FETCH.
- EXECUTER: alu_src_a 10, alu_src_b 00, funct-decode; → ALUWB.
- EXECUTEI: alu_src_a 10, alu_src_b 01, funct-decode (funct7b5 ignored since op[5]=0); → ALUWB.
- ALUWB: result_src 00, reg_write=1; → FETCH.
- BRANCH: alu_src_a 10, alu_src_b 00, sub, result_src 00; pc_write = zero XOR funct3[0] (beq/bne); → FETCH.
- JAL: alu_src_a 01, alu_src_b 10, add, result_src 00, pc_write=1; → ALUWB (writes OldPC+4).
- JALR_ADR (macro only): alu_src_a 10, alu_src_b 01, add; → JAL.
- Reset: state ← FETCH; while rst high pc_write, ir_write, mem_write, reg_write, illegal forced 0. Reset mid-instruction abandons it; no partial write after the reset edge.

## Timing
- Outputs are Moore functions of state (plus mem_ready/zero gating where stated); no output registers.
- With mem_ready held 1: lw 5 cycles, sw/R/I/jal 4, branch 3, jalr 5, illegal 2 (FETCH, DECODE).
- Each mem_ready=0 cycle in FETCH/MEMREAD/MEMWRITE adds exactly one cycle; no enable pulses repeat during the stall.
- illegal asserts only in DECODE, exactly one cycle per illegal instruction.

## Configuration
- MULTICYCLE_JALR_EN defined: opcode 1100111 decodes to JALR_ADR → JAL → ALUWB; PC ← rs1+imm, rd ← OldPC+4.
- Undefined: JALR_ADR state absent; 1100111 treated as illegal (pulse, return to FETCH, no writes).

## Test plan
- Reset: rst high 2 cycles with mem_ready=1 → all enables 0; first cycle after release is FETCH with ir_write=1, pc_write=1.
- lw (op 0000011), mem_ready=1 → reg_write=1 in cycle 5 with result_src=01; mem_write never asserted.
- sw with mem_ready low 3 cycles in MEMWRITE → mem_write high 4 consecutive cycles, then FETCH; total 7 cycles.
- beq zero=1 → pc_write=1 in BRANCH; bne (funct3 001) zero=1 → pc_write=0; imm_src=10 both.
- R-type funct3 000 funct7b5=1 → alu_control 001 in EXECUTER; I-type same fields → 000.
- op 1100111 → with MULTICYCLE_JALR_EN: states JALR_ADR, JAL, ALUWB, reg_write in cycle 5; without: illegal=1 in cycle 2, no reg_write/pc_write beyond FETCH.
